// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and frame lengths for the SD command engine
package sd_pkg;

    localparam int CMD_LEN  = 48;
    localparam int LONG_LEN = 136;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_SHORT = 2'd1,
        RESP_LONG  = 2'd2,
        RESP_BUSY  = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RECV,
        BUSY,
        GAP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7 + x^3 + 1), MSB first, clear has priority
module sd_crc7 (
    input  logic       sdClock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data,
    output logic [6:0] crc
);

    logic fb;

    assign fb = data ^ crc[6];

    always_ff @(posedge sdClock) begin
        if (!reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD CMD-line engine: command send, response receive/check, busy wait
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BUSY_TIMEOUT   = 65535,
    parameter int NCC_CYCLES     = 8
) (
    input  logic         sdClock,
    input  logic         reset,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe,
    input  logic         dat0_i,
    input  logic         start,
    output logic         ready,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         check_en,
    output logic         done,
    output logic         timeout,
    output logic         crc_err,
    output logic         index_err,
    output logic         busy_timeout,
    output logic [5:0]   resp_index,
    output logic [119:0] resp_arg
);

    localparam int CNT_MAX = max3(LONG_LEN, TIMEOUT_CYCLES, BUSY_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    resp_t              rtype;
    logic               chk;
    logic [5:0]         idx_q;
    logic [CNT_W-1:0]   cnt;
    logic [38:0]        tx_sr;
    logic [132:0]       rx_sr;
    logic [133:0]       rx_full;
    logic               is_long;
    logic [CNT_W-1:0]   rx_last;
    logic [2:0]         crc_sel;
    logic               crc_ok;
    logic               crc_clear;
    logic               crc_en;
    logic               crc_data;
    logic [6:0]         crc_val;

    sd_crc7 u_crc7 (
        .sdClock (sdClock),
        .reset   (reset),
        .clear   (crc_clear),
        .enable  (crc_en),
        .data    (crc_data),
        .crc     (crc_val)
    );

    always_comb begin
        rx_full = {rx_sr, cmd_i};
        is_long = (rtype == RESP_LONG);
        rx_last = is_long ? CNT_W'(LONG_LEN - 2) : CNT_W'(CMD_LEN - 2);
        crc_sel = 3'(6'd45 - cnt[5:0]);
        crc_ok  = (rx_full[7:1] == crc_val) && rx_full[0];
    end

    // Clearing stands in for feeding the leading 0 start bit: CRC of a zero bit from zero is zero.
    always_comb begin
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        crc_data  = 1'b0;
        case (state)
            IDLE:      crc_clear = start;
            SEND: begin
                crc_en   = (cnt < CNT_W'(39));
                crc_data = tx_sr[38];
            end
            WAIT_RESP: crc_clear = ~cmd_i;
            RECV: begin
                crc_en   = is_long ? (cnt >= CNT_W'(7) && cnt <= CNT_W'(126))
                                   : (cnt <= CNT_W'(38));
                crc_data = cmd_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sdClock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ready        <= 1'b1;
            cmd_o        <= 1'b1;
            cmd_oe       <= 1'b1;
            done         <= 1'b0;
            timeout      <= 1'b0;
            crc_err      <= 1'b0;
            index_err    <= 1'b0;
            busy_timeout <= 1'b0;
            resp_index   <= '0;
            resp_arg     <= '0;
            rtype        <= RESP_NONE;
            chk          <= 1'b0;
            idx_q        <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rtype        <= resp_t'(resp_type);
                    chk          <= check_en;
                    idx_q        <= cmd_index;
                    tx_sr        <= {1'b1, cmd_index, cmd_arg};
                    timeout      <= 1'b0;
                    crc_err      <= 1'b0;
                    index_err    <= 1'b0;
                    busy_timeout <= 1'b0;
                    resp_index   <= '0;
                    resp_arg     <= '0;
                    ready        <= 1'b0;
                    cmd_o        <= 1'b0;
                    cnt          <= '0;
                    state        <= SEND;
                end
                // cnt is the bit on the wire; cmd_o is loaded with the following bit.
                SEND: begin
                    cnt <= cnt + 1'b1;
                    if (cnt < CNT_W'(39)) begin
                        cmd_o <= tx_sr[38];
                        tx_sr <= {tx_sr[37:0], 1'b0};
                    end else if (cnt < CNT_W'(46)) begin
                        cmd_o <= crc_val[crc_sel];
                    end else if (cnt == CNT_W'(46)) begin
                        cmd_o <= 1'b1;
                    end else begin
                        cnt <= '0;
                        if (rtype == RESP_NONE) begin
                            state <= GAP; done <= 1'b1;
                        end else begin
                            state <= WAIT_RESP; cmd_oe <= 1'b0;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (!cmd_i) begin
                        state <= RECV; cnt <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        state <= GAP; cnt <= '0; done <= 1'b1; cmd_o <= 1'b1; cmd_oe <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECV: begin
                    rx_sr <= rx_full[132:0];
                    if (cnt == rx_last) begin
                        resp_index <= is_long ? rx_full[133:128] : rx_full[45:40];
                        resp_arg   <= is_long ? rx_full[127:8] : {88'b0, rx_full[39:8]};
                        crc_err    <= chk & ~crc_ok;
                        index_err  <= chk & ~is_long & (rx_full[45:40] != idx_q);
                        cnt        <= '0;
                        if (rtype == RESP_BUSY) begin
                            state <= BUSY;
                        end else begin
                            state <= GAP; done <= 1'b1; cmd_o <= 1'b1; cmd_oe <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The card may not have pulled DAT0 low yet in the first two cycles.
                BUSY: begin
                    if (cnt >= CNT_W'(2) && dat0_i) begin
                        state <= GAP; cnt <= '0; done <= 1'b1; cmd_o <= 1'b1; cmd_oe <= 1'b1;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        busy_timeout <= 1'b1;
                        state <= GAP; cnt <= '0; done <= 1'b1; cmd_o <= 1'b1; cmd_oe <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(NCC_CYCLES - 1)) begin
                        state <= IDLE; ready <= 1'b1; cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - directed self-checking bench for sd_cmd_engine
module tb_sd_cmd_engine;

    logic         sdClock = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_i = 1'b1;
    logic         dat0_i = 1'b1;
    logic         start = 1'b0;
    logic         check_en = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         cmd_o, cmd_oe, ready, done, timeout, crc_err, index_err, busy_timeout;
    logic [5:0]   resp_index;
    logic [119:0] resp_arg;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [119:0] CID  = 120'h035344534431364780123456780123;
    localparam logic [119:0] FLIP = 120'h1 << 50;

    always #5 sdClock = ~sdClock;

    sd_cmd_engine #(.TIMEOUT_CYCLES(1024), .BUSY_TIMEOUT(65535), .NCC_CYCLES(8)) dut (
        .sdClock(sdClock), .reset(reset), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe),
        .dat0_i(dat0_i), .start(start), .ready(ready), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .check_en(check_en), .done(done),
        .timeout(timeout), .crc_err(crc_err), .index_err(index_err),
        .busy_timeout(busy_timeout), .resp_index(resp_index), .resp_arg(resp_arg)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_calc(input logic [127:0] v, input int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c = {c[5:0], fb};
            c[3] = c[3] ^ fb;
        end
        return c;
    endfunction

    function automatic logic [47:0] short_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b00, idx, arg};
        return {h, crc7_calc({88'b0, h}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] cid, input logic [119:0] flip);
        return {2'b00, 6'h3f, cid ^ flip, crc7_calc({8'b0, cid}, 120), 1'b1};
    endfunction

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt, input logic ce);
        @(negedge sdClock);
        cmd_index = idx; cmd_arg = arg; resp_type = rt; check_en = ce; start = 1'b1;
        @(negedge sdClock);
        start = 1'b0;
    endtask

    task automatic capture(output logic [47:0] bits, output logic oe_all);
        bits[47] = cmd_o;
        oe_all = cmd_oe;
        for (int i = 46; i >= 0; i--) begin
            @(negedge sdClock);
            bits[i] = cmd_o;
            oe_all = oe_all & cmd_oe;
        end
    endtask

    task automatic respond(input logic [135:0] v, input int n);
        @(negedge sdClock);
        check_val("wait_resp_oe", cmd_oe, 0);
        for (int i = n - 1; i >= 0; i--) begin
            cmd_i = v[i];
            @(negedge sdClock);
        end
        cmd_i = 1'b1;
    endtask

    task automatic wait_done(output int n, input int limit);
        n = 0;
        while (!done && n < limit) begin
            @(negedge sdClock);
            n++;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge sdClock);
            n++;
        end
        check_val("ready_back", ready, 1);
    endtask

    initial begin
        logic [47:0] tx;
        logic        oe;
        int          n;
        int          dones;

        repeat (3) @(negedge sdClock);
        check_val("rst_ready", ready, 1);
        check_val("rst_lines", {cmd_oe, cmd_o}, 2'b11);
        check_val("rst_done", done, 0);
        check_val("rst_flags", {timeout, crc_err, index_err, busy_timeout}, 0);
        check_val("rst_resp", {resp_index, resp_arg}, 0);
        reset = 1'b1;

        issue(6'd0, 32'h0, 2'd0, 1'b1);
        capture(tx, oe);
        check_val("cmd0_tx", tx, 48'h400000000095);
        check_val("cmd0_oe", oe, 1);
        wait_done(n, 10);
        check_val("cmd0_done_lat", n, 1);
        n = 0; oe = 1'b1;
        while (!ready && n < 50) begin
            oe = oe & cmd_oe & cmd_o;
            @(negedge sdClock);
            n++;
        end
        check_val("cmd0_gap_len", n, 8);
        check_val("cmd0_gap_lines", oe, 1);

        issue(6'd8, 32'h1AA, 2'd1, 1'b1);
        capture(tx, oe);
        check_val("cmd8_tx", tx, 48'h48000001AA87);
        respond({88'b0, 48'h48000001AA87}, 48);
        wait_done(n, 10);
        check_val("cmd8_done_lat", n, 0);
        check_val("cmd8_index", resp_index, 8);
        check_val("cmd8_arg", resp_arg, 120'h1AA);
        check_val("cmd8_flags", {timeout, crc_err, index_err}, 0);
        wait_ready();

        issue(6'd8, 32'h1AA, 2'd1, 1'b1);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd9, 32'h1AA)}, 48);
        wait_done(n, 10);
        check_val("idx_err_flags", {crc_err, index_err}, 2'b01);
        check_val("idx_err_index", resp_index, 9);
        wait_ready();

        issue(6'd8, 32'h1AA, 2'd1, 1'b0);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd9, 32'h1AA) ^ 48'h2}, 48);
        wait_done(n, 10);
        check_val("nochk_flags", {crc_err, index_err}, 2'b00);
        wait_ready();

        issue(6'd3, 32'h5, 2'd1, 1'b1);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd3, 32'h5) & ~48'h1}, 48);
        wait_done(n, 10);
        check_val("endbit_flags", {crc_err, index_err}, 2'b10);
        wait_ready();

        issue(6'd17, 32'h200, 2'd1, 1'b1);
        capture(tx, oe);
        @(negedge sdClock);
        cmd_index = 6'd5; start = 1'b1;
        @(negedge sdClock);
        start = 1'b0;
        wait_done(n, 2000);
        check_val("to_latency", n, 1023);
        check_val("to_flag", timeout, 1);
        check_val("to_cleared", {crc_err, resp_arg}, 0);
        wait_ready();

        issue(6'd2, 32'h0, 2'd2, 1'b1);
        capture(tx, oe);
        respond(long_frame(CID, '0), 136);
        wait_done(n, 10);
        check_val("cid_lat", n, 0);
        check_val("cid_arg", resp_arg, CID);
        check_val("cid_crc", crc_err, 0);
        wait_ready();

        issue(6'd2, 32'h0, 2'd2, 1'b1);
        capture(tx, oe);
        respond(long_frame(CID, FLIP), 136);
        wait_done(n, 10);
        check_val("cidflip_arg", resp_arg, CID ^ FLIP);
        check_val("cidflip_crc", crc_err, 1);
        wait_ready();

        dat0_i = 1'b0;
        issue(6'd7, 32'h12340000, 2'd3, 1'b1);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd7, 32'h12340000)}, 48);
        repeat (99) @(negedge sdClock);
        dat0_i = 1'b1;
        wait_done(n, 10);
        check_val("busy_rel_lat", n, 1);
        check_val("busy_rel_flags", {busy_timeout, crc_err, index_err}, 0);
        wait_ready();

        issue(6'd7, 32'h12340000, 2'd3, 1'b1);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd7, 32'h12340000)}, 48);
        wait_done(n, 10);
        check_val("busy_ignore_lat", n, 3);
        wait_ready();

        dat0_i = 1'b0;
        issue(6'd7, 32'h12340000, 2'd3, 1'b1);
        capture(tx, oe);
        respond({88'b0, short_frame(6'd7, 32'h12340000)}, 48);
        wait_done(n, 70000);
        check_val("busy_to_lat", n, 65535);
        check_val("busy_to_flag", busy_timeout, 1);
        dat0_i = 1'b1;
        wait_ready();

        issue(6'd1, 32'h0, 2'd1, 1'b1);
        repeat (20) @(negedge sdClock);
        reset = 1'b0;
        @(negedge sdClock);
        check_val("abort_lines", {cmd_oe, cmd_o}, 2'b11);
        check_val("abort_ready", ready, 1);
        check_val("abort_done", done, 0);
        reset = 1'b1;
        dones = 0;
        repeat (80) begin
            @(negedge sdClock);
            if (done) dones++;
        end
        check_val("abort_no_done", dones, 0);
        check_val("abort_idle", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
